// File: rtl/enc_input_filter.sv
// Quadrature encoder pin conditioning: synchroniser plus per-channel
// consecutive-sample glitch filter, with change strobe and debug counters.
module enc_input_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 1024
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       enc_a_raw,
  input  logic       enc_b_raw,
  input  logic       clr_err,
  output logic       enc_a,
  output logic       enc_b,
  output logic       enc_changed,
  output logic       err_double,
  output logic [7:0] glitch_cnt
);

  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_a_q;
  logic [SYNC_STAGES-1:0] sync_b_q;
  logic [1:0]             s;
  logic [1:0]             lvl_q, lvl_d;
  logic [1:0][CW-1:0]     cnt_q, cnt_d;
  logic [1:0]             commit;
  logic [1:0]             abandon;
  logic                   chg_q, chg_d;
  logic                   err_q, err_d;
  logic [7:0]             glitch_q, glitch_d;
  logic [7:0]             gbase;
  logic [8:0]             gsum;

  assign s = {sync_b_q[SYNC_STAGES-1], sync_a_q[SYNC_STAGES-1]};

  // Index 0 is channel A, index 1 is channel B.
  always_comb begin
    lvl_d   = lvl_q;
    cnt_d   = cnt_q;
    commit  = '0;
    abandon = '0;
    for (int c = 0; c < 2; c++) begin
      if (s[c] == lvl_q[c]) begin
        if (cnt_q[c] != '0) begin
          cnt_d[c]   = '0;
          abandon[c] = 1'b1;
        end
      end else if (cnt_q[c] == CNT_LAST) begin
        lvl_d[c]  = s[c];
        cnt_d[c]  = '0;
        commit[c] = 1'b1;
      end else begin
        cnt_d[c] = cnt_q[c] + CW'(1);
      end
    end
  end

  always_comb begin
    chg_d    = |commit;
    err_d    = (&commit) | (err_q & ~clr_err);
    gbase    = clr_err ? 8'h00 : glitch_q;
    gsum     = {1'b0, gbase} + 9'(abandon[0]) + 9'(abandon[1]);
    glitch_d = gsum[8] ? 8'hFF : gsum[7:0];
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
      lvl_q    <= '0;
      cnt_q    <= '0;
      chg_q    <= 1'b0;
      err_q    <= 1'b0;
      glitch_q <= '0;
    end else begin
      sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], enc_a_raw};
      sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], enc_b_raw};
      lvl_q    <= lvl_d;
      cnt_q    <= cnt_d;
      chg_q    <= chg_d;
      err_q    <= err_d;
      glitch_q <= glitch_d;
    end
  end

  assign enc_a       = lvl_q[0];
  assign enc_b       = lvl_q[1];
  assign enc_changed = chg_q;
  assign err_double  = err_q;
  assign glitch_cnt  = glitch_q;

endmodule

// File: tb/tb_enc_input_filter.sv
// Bench for enc_input_filter: directed vector table, corner sequences,
// and random stimulus against a sample-window reference model.
module tb_enc_input_filter;

  localparam int SYNC = 2;
  localparam int FC   = 4;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       enc_a_raw, enc_b_raw, clr_err;
  logic       enc_a, enc_b, enc_changed, err_double;
  logic [7:0] glitch_cnt;

  int checks = 0;
  int errs   = 0;

  enc_input_filter #(.SYNC_STAGES(SYNC), .FILTER_CYCLES(FC)) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .enc_a_raw  (enc_a_raw),
    .enc_b_raw  (enc_b_raw),
    .clr_err    (clr_err),
    .enc_a      (enc_a),
    .enc_b      (enc_b),
    .enc_changed(enc_changed),
    .err_double (err_double),
    .glitch_cnt (glitch_cnt)
  );

  always #5 sysclk = ~sysclk;

  // Reference model: a level commits once the last FC synchronised
  // samples all differ from it; a pending run that ends early is a glitch.
  bit m_rh [2][SYNC];
  bit m_sh [2][FC];
  bit m_q  [2];
  bit m_raw[2];
  bit m_chg, m_err, m_s, m_prev, m_all;
  int m_gl, m_nc, m_na;

  always @(posedge sysclk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < SYNC; i++) m_rh[c][i] = 1'b0;
        for (int i = 0; i < FC; i++) m_sh[c][i] = 1'b0;
        m_q[c] = 1'b0;
      end
      m_chg = 1'b0;
      m_err = 1'b0;
      m_gl  = 0;
    end else begin
      m_raw[0] = enc_a_raw;
      m_raw[1] = enc_b_raw;
      m_nc = 0;
      m_na = 0;
      for (int c = 0; c < 2; c++) begin
        m_s = m_rh[c][SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) m_rh[c][i] = m_rh[c][i-1];
        m_rh[c][0] = m_raw[c];
        m_prev = m_sh[c][0];
        for (int i = FC - 1; i > 0; i--) m_sh[c][i] = m_sh[c][i-1];
        m_sh[c][0] = m_s;
        m_all = 1'b1;
        for (int i = 0; i < FC; i++)
          if (m_sh[c][i] == m_q[c]) m_all = 1'b0;
        if (m_s == m_q[c] && m_prev != m_q[c]) m_na++;
        if (m_all) begin
          m_q[c] = m_s;
          m_nc++;
        end
      end
      m_chg = (m_nc > 0);
      m_err = (m_nc == 2) || (m_err && !clr_err);
      if (clr_err) m_gl = 0;
      m_gl = m_gl + m_na;
      if (m_gl > 255) m_gl = 255;
    end
  end

  task automatic chk(input string nm, input logic [8:0] act,
                     input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("mdl_enc_a", 9'(enc_a), 9'(m_q[0]));
    chk("mdl_enc_b", 9'(enc_b), 9'(m_q[1]));
    chk("mdl_changed", 9'(enc_changed), 9'(m_chg));
    chk("mdl_err", 9'(err_double), 9'(m_err));
    chk("mdl_glitch", 9'(glitch_cnt), 9'(m_gl));
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sysclk);
      @(negedge sysclk);
      cmp_model();
    end
  endtask

  task automatic chk_out(input string nm, input bit ea, input bit eb,
                         input bit ec, input bit ee, input int eg);
    chk({nm, ".enc_a"}, 9'(enc_a), 9'(ea));
    chk({nm, ".enc_b"}, 9'(enc_b), 9'(eb));
    chk({nm, ".changed"}, 9'(enc_changed), 9'(ec));
    chk({nm, ".err"}, 9'(err_double), 9'(ee));
    chk({nm, ".glitch"}, 9'(glitch_cnt), 9'(eg));
  endtask

  typedef struct {
    bit a, b, clr;
    int cyc;
    bit ea, eb, ec, ee;
    int eg;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit a, bit b, bit clr, int cyc,
                              bit ea, bit eb, bit ec, bit ee, int eg);
    vec_t v;
    v.a = a; v.b = b; v.clr = clr; v.cyc = cyc;
    v.ea = ea; v.eb = eb; v.ec = ec; v.ee = ee; v.eg = eg;
    tbl.push_back(v);
  endfunction

  initial begin
    // latency, one-cycle strobe
    add(1, 0, 0, 5,  0, 0, 0, 0, 0);
    add(1, 0, 0, 1,  1, 0, 1, 0, 0);
    add(1, 0, 0, 1,  1, 0, 0, 0, 0);
    // 3-cycle glitch on B
    add(1, 1, 0, 3,  1, 0, 0, 0, 0);
    add(1, 0, 0, 3,  1, 0, 0, 0, 1);
    add(1, 0, 0, 4,  1, 0, 0, 0, 1);
    // simultaneous step, then clear
    add(0, 0, 0, 8,  0, 0, 0, 0, 1);
    add(1, 1, 0, 6,  1, 1, 1, 1, 1);
    add(1, 1, 1, 1,  1, 1, 0, 0, 0);
    add(1, 1, 0, 2,  1, 1, 0, 0, 0);
    add(0, 0, 0, 10, 0, 0, 0, 1, 0);
    add(0, 0, 1, 1,  0, 0, 0, 0, 0);
    // CW quadrature 00 -> 01 -> 11 -> 10 -> 00, 10 cycles per state
    add(0, 1, 0, 6,  0, 1, 1, 0, 0);
    add(0, 1, 0, 4,  0, 1, 0, 0, 0);
    add(1, 1, 0, 6,  1, 1, 1, 0, 0);
    add(1, 1, 0, 4,  1, 1, 0, 0, 0);
    add(1, 0, 0, 6,  1, 0, 1, 0, 0);
    add(1, 0, 0, 4,  1, 0, 0, 0, 0);
    add(0, 0, 0, 6,  0, 0, 1, 0, 0);
    add(0, 0, 0, 4,  0, 0, 0, 0, 0);

    reset = 1'b1;
    enc_a_raw = 1'b0;
    enc_b_raw = 1'b0;
    clr_err = 1'b0;
    repeat (2) @(negedge sysclk);
    chk_out("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;

    foreach (tbl[k]) begin
      enc_a_raw = tbl[k].a;
      enc_b_raw = tbl[k].b;
      clr_err   = tbl[k].clr;
      step(tbl[k].cyc);
      chk_out($sformatf("vec%0d", k), tbl[k].ea, tbl[k].eb,
              tbl[k].ec, tbl[k].ee, tbl[k].eg);
    end
    clr_err = 1'b0;

    // glitch counter saturation
    for (int g = 0; g < 300; g++) begin
      enc_a_raw = 1'b1;
      enc_b_raw = 1'b1;
      step(3);
      enc_a_raw = 1'b0;
      enc_b_raw = 1'b0;
      step(5);
    end
    chk_out("sat", 0, 0, 0, 0, 255);
    step(10);
    chk_out("sat_hold", 0, 0, 0, 0, 255);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    chk_out("sat_clr", 0, 0, 0, 0, 0);

    // async reset with A committed and B pending
    enc_a_raw = 1'b1;
    step(8);
    chk_out("pre_rst", 1, 0, 0, 0, 0);
    enc_b_raw = 1'b1;
    step(4);
    #2 reset = 1'b1;
    #1 chk_out("async_rst", 0, 0, 0, 0, 0);
    @(negedge sysclk);
    reset = 1'b0;
    step(5);
    chk_out("rst_lat5", 0, 0, 0, 0, 0);
    step(1);
    chk_out("rst_lat6", 1, 1, 1, 1, 0);

    // random stimulus against the model
    for (int r = 0; r < 300; r++) begin
      enc_a_raw = 1'($urandom);
      enc_b_raw = 1'($urandom);
      clr_err   = ($urandom_range(7) == 0);
      step(1);
      clr_err = 1'b0;
      step($urandom_range(8));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
